// File: rtl/adder_arb_pkg.sv
// Shared types and constants for adder_arbiter: FSM state encoding and the
// active-high gfedcba seven-segment table used when ADDER_ARB_SEG_EN is defined.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned SEG_BITS = 7;

    localparam logic [SEG_BITS-1:0] SEG_BLANK = '0;

    localparam logic [SEG_BITS-1:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [SEG_BITS-1:0] seg_lookup(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex-to-seven-segment lookup; only instantiated by adder_arbiter
// when ADDER_ARB_SEG_EN is defined.
module seg_hex_decoder
    import adder_arb_pkg::*;
#(
    parameter int unsigned SEG_WIDTH = 7
) (
    input  logic [3:0]           hex,
    output logic [SEG_WIDTH-1:0] seg
);

    always_comb begin
        seg = SEG_WIDTH'(seg_lookup(hex));
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder between NUM_REQ requesters (IDLE/CALC/RESP).
// Define ADDER_ARB_SEG_EN to drive rsp_seg from the seven-segment decoder; otherwise rsp_seg is 0.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 3,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned SEG_WIDTH  = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_sum,
    output logic                          rsp_carry,
    output logic [SEG_WIDTH-1:0]          rsp_seg,
    output logic                          busy
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    state_t                state;
    logic [ID_W-1:0]       rr_ptr;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [ID_W-1:0]       op_id;

    logic                  found;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W-1:0]       cand;
    logic [DATA_WIDTH:0]   sum_full;
    logic [SEG_WIDTH-1:0]  seg_next;
    logic [ID_W-1:0]       next_ptr;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && found)
            req_ready[grant_idx] = 1'b1;
    end

    assign sum_full = {1'b0, op_a} + {1'b0, op_b};
    assign next_ptr = (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + ID_W'(1);

`ifdef ADDER_ARB_SEG_EN
    logic [3:0] hex_in;
    assign hex_in = 4'(sum_full[DATA_WIDTH-1:0]);

    seg_hex_decoder #(
        .SEG_WIDTH (SEG_WIDTH)
    ) u_seg (
        .hex (hex_in),
        .seg (seg_next)
    );
`else
    assign seg_next = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
            rsp_seg   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a  <= req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                        op_b  <= req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                        op_id <= grant_idx;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum   <= sum_full[DATA_WIDTH-1:0];
                    rsp_carry <= sum_full[DATA_WIDTH];
                    rsp_id    <= op_id;
                    rsp_seg   <= seg_next;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed scoreboard bench for adder_arbiter; expected seg codes follow ADDER_ARB_SEG_EN.
module tb_adder_arbiter;

    localparam int DW = 3;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int SW = 7;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*DW-1:0]   req_a;
    logic [NR*DW-1:0]   req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IW-1:0]      rsp_id;
    logic [DW-1:0]      rsp_sum;
    logic               rsp_carry;
    logic [SW-1:0]      rsp_seg;
    logic               busy;

    always #5 clk = ~clk;

    adder_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .SEG_WIDTH  (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_seg   (rsp_seg),
        .busy      (busy)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] sum;
        logic          carry;
        logic [SW-1:0] seg;
    } exp_t;

    exp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [SW-1:0] ref_seg(input int v);
        logic [SW-1:0] s;
        case (v)
            0:  s = 7'b0111111;  1:  s = 7'b0000110;
            2:  s = 7'b1011011;  3:  s = 7'b1001111;
            4:  s = 7'b1100110;  5:  s = 7'b1101101;
            6:  s = 7'b1111101;  7:  s = 7'b0000111;
            8:  s = 7'b1111111;  9:  s = 7'b1101111;
            10: s = 7'b1110111;  11: s = 7'b1111100;
            12: s = 7'b0111001;  13: s = 7'b1011110;
            14: s = 7'b1111001;  default: s = 7'b1110001;
        endcase
`ifndef ADDER_ARB_SEG_EN
        s = '0;
`endif
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*DW +: DW] = DW'(a);
        req_b[i*DW +: DW] = DW'(b);
    endtask

    task automatic push_exp(input int id, input int a, input int b);
        exp_t e;
        int   s;
        s       = a + b;
        e.id    = IW'(id);
        e.sum   = DW'(s % 8);
        e.carry = (s >= 8);
        e.seg   = ref_seg(s % 8);
        sb.push_back(e);
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_id"},    32'(rsp_id),    32'(e.id));
            chk({tag, "_sum"},   32'(rsp_sum),   32'(e.sum));
            chk({tag, "_carry"}, 32'(rsp_carry), 32'(e.carry));
            chk({tag, "_seg"},   32'(rsp_seg),   32'(e.seg));
        end
    endtask

    // Called in an IDLE cycle with rsp_ready high; grant, CALC, RESP, back to IDLE.
    task automatic run_op(input logic [NR-1:0] exp_ready, input bit drop, input string tag);
        #1 chk({tag, "_grant"}, 32'(req_ready), 32'(exp_ready));
        @(negedge clk);
        if (drop) req_valid = '0;
        #1;
        chk({tag, "_calc_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_calc_ready"}, 32'(req_ready), 0);
        chk({tag, "_calc_busy"},  32'(busy), 1);
        @(negedge clk);
        #1 check_rsp(tag);
        @(negedge clk);
        #1;
        chk({tag, "_idle_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_idle_busy"},  32'(busy), 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_sum",   32'(rsp_sum), 0);
        chk("rst_carry", 32'(rsp_carry), 0);
        chk("rst_id",    32'(rsp_id), 0);
        chk("rst_seg",   32'(rsp_seg), 0);
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);

        set_op(0, 2, 3);
        req_valid = 4'b0001;
        push_exp(0, 2, 3);
        run_op(4'b0001, 1'b1, "single");

        set_op(1, 5, 7);
        req_valid = 4'b0010;
        push_exp(1, 5, 7);
        run_op(4'b0010, 1'b1, "ovf57");

        set_op(1, 7, 7);
        req_valid = 4'b0010;
        push_exp(1, 7, 7);
        run_op(4'b0010, 1'b1, "ovf77");

        // Reset while CALC: the req2 operation must vanish.
        set_op(2, 3, 3);
        req_valid = 4'b0100;
        #1 chk("rstcalc_grant", 32'(req_ready), 32'(4'b0100));
        @(negedge clk);
        req_valid = '0;
        #1 chk("rstcalc_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rstcalc_valid", 32'(rsp_valid), 0);
        chk("rstcalc_busy0", 32'(busy), 0);
        chk("rstcalc_sum",   32'(rsp_sum), 0);
        chk("rstcalc_id",    32'(rsp_id), 0);
        @(negedge clk);
        #1 chk("rstcalc_hold_valid", 32'(rsp_valid), 0);
        rst = 1'b0;
        set_op(0, 6, 1);
        req_valid = 4'b0101;
        push_exp(0, 6, 1);
        run_op(4'b0001, 1'b1, "post_rst");

        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NR; i++) begin
            set_op(i, i, i + 1);
            push_exp(i, i, i + 1);
        end
        push_exp(0, 0, 1);
        req_valid = '1;
        for (int k = 0; k < 5; k++)
            run_op(NR'(1) << (k % NR), k == 4, $sformatf("cont%0d", k));

        // Backpressure; operand changes after capture must not leak into the result.
        set_op(3, 1, 6);
        req_valid = 4'b1000;
        push_exp(3, 1, 6);
        rsp_ready = 1'b0;
        #1 chk("bp_grant", 32'(req_ready), 32'(4'b1000));
        @(negedge clk);
        req_valid = '0;
        set_op(3, 0, 0);
        #1 chk("bp_calc_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        #1 check_rsp("bp");
        req_valid = 4'b0001;
        set_op(0, 4, 4);
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp_hold%0d_valid", h), 32'(rsp_valid), 1);
            chk($sformatf("bp_hold%0d_sum", h),   32'(rsp_sum), 7);
            chk($sformatf("bp_hold%0d_id", h),    32'(rsp_id), 3);
            chk($sformatf("bp_hold%0d_ready", h), 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_release_valid", 32'(rsp_valid), 0);
        chk("bp_release_busy",  32'(busy), 0);
        push_exp(0, 4, 4);
        run_op(4'b0001, 1'b1, "bp_next");

        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
